// File: rtl/decode_pipe_buffer_pkg.sv
// Shared fetch/decode types and constants for the stage buffers.
package decode_pipe_buffer_pkg;

  localparam int WORD_W     = 32;
  localparam int PC_STEP    = 4;
  localparam int ALIGN_BITS = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/decode_pipe_buffer_sync_fifo_ctrl.sv
// Pointer/occupancy control for a small power-of-two FIFO with flush.
module sync_fifo_ctrl #(
  parameter int DEPTH = 2,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push_valid,
  input  logic          pop_ready,
  output logic          push_ready,
  output logic          pop_valid,
  output logic          push_en,
  output logic [PW-1:0] wptr,
  output logic [PW-1:0] rptr,
  output logic [PW:0]   count
);

  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW:0]   count_q, count_d;
  logic          pop_en;

  // Ready comes only from registered occupancy, so a same-cycle pop never frees a slot early.
  assign push_ready = !reset && (count_q != FULL_COUNT);
  assign pop_valid  = (count_q != '0);
  assign push_en    = push_valid && push_ready && !flush;
  assign pop_en     = pop_valid && pop_ready && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) wptr_d = wptr_q + PW'(1);
      if (pop_en)  rptr_d = rptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push_en) - (PW+1)'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr  = wptr_q;
  assign rptr  = rptr_q;
  assign count = count_q;

endmodule

// File: rtl/decode_pipe_buffer.sv
// Fetch-to-decode buffer: queues (pc, instr) pairs and presents the head with pc+4 and misalignment flag.
module decode_pipe_buffer
  import decode_pipe_buffer_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int WORD_WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_WIDTH-1:0]    in_pc,
  input  logic [WORD_WIDTH-1:0]    in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_WIDTH-1:0]    out_pc,
  output logic [WORD_WIDTH-1:0]    out_instr,
  output logic [WORD_WIDTH-1:0]    out_pcplus4,
  output logic                     out_addr_err,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int PW = $clog2(DEPTH);

  logic          push_en;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  logic [WORD_WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem_d    [DEPTH];
  logic [WORD_WIDTH-1:0] instr_mem_q [DEPTH];
  logic [WORD_WIDTH-1:0] instr_mem_d [DEPTH];

  sync_fifo_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push_valid (in_valid),
    .pop_ready  (out_ready),
    .push_ready (in_ready),
    .pop_valid  (out_valid),
    .push_en    (push_en),
    .wptr       (wptr),
    .rptr       (rptr),
    .count      (out_count)
  );

  always_comb begin
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (push_en) begin
      pc_mem_d[wptr]    = in_pc;
      instr_mem_d[wptr] = in_instr;
    end
  end

  // Storage is deliberately left unreset; out_valid masks stale contents.
  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

  assign out_pc       = out_valid ? pc_mem_q[rptr]    : '0;
  assign out_instr    = out_valid ? instr_mem_q[rptr] : '0;
  assign out_pcplus4  = out_valid ? (pc_mem_q[rptr] + WORD_WIDTH'(PC_STEP)) : '0;
  assign out_addr_err = |out_pc[ALIGN_BITS-1:0];

endmodule

// File: doc/decode_pipe_buffer.md
Name: decode_pipe_buffer

Overview:
- Fetch-to-decode pipeline buffer: consumer-side counterpart of the fetch stage's pc/instr producer.
- Accepts (pc, instr) pairs from fetch under a valid/ready handshake.
- Buffers up to DEPTH entries and presents them in order to decode with pcplus4 and an address-error flag.
- Absorbs decode stalls without dropping in-flight fetches; flush (branch mispredict/exception) discards all buffered entries.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, >= 2
- WORD_WIDTH, 32, width of pc/instr (matches word_t)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid pc/instr pair
- in_ready  output  1  buffer can accept this cycle
- in_pc  input  WORD_WIDTH  fetched pc
- in_instr  input  WORD_WIDTH  fetched instruction
- flush  input  1  discard all entries and any same-cycle push
- out_valid  output  1  head entry valid to decode
- out_ready  input  1  decode consumes head this cycle
- out_pc  output  WORD_WIDTH  head pc
- out_instr  output  WORD_WIDTH  head instruction
- out_pcplus4  output  WORD_WIDTH  head pc + 4
- out_addr_err  output  1  head pc[1:0] != 0
- out_count  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- State: DEPTH-entry storage array, read pointer, write pointer ($clog2(DEPTH) bits each, wrap modulo DEPTH), occupancy counter.
- Reset: count=0, both pointers=0, out_valid=0, out_count=0. out_pc/out_instr/out_pcplus4 read as 0 while empty. Storage contents are not reset.
- in_ready = !reset && count < DEPTH. Depends only on registered state, never on out_ready (no combinational ready path).
- out_valid = count != 0. Outputs are driven from the entry at the read pointer.
- Push = in_valid & in_ready & !flush: write at wptr, wptr++.
- Pop = out_valid & out_ready & !flush: rptr++.
- Push and pop in the same cycle: count unchanged, both pointers advance.
- Full: in_ready=0, and a same-cycle pop does not enable a push. Full-to-nonfull takes effect the next cycle.
- Empty: no bypass. Data pushed in cycle N appears on out_* in cycle N+1 (latency 1).
- Flush: next cycle count=0, rptr=wptr=0, out_valid=0. A push or pop presented with flush is ignored. in_ready remains 1 during flush unless full.
- Reset asserted mid-operation: identical to reset; overrides flush.
- out_pcplus4 = out_pc + 4, truncated to WORD_WIDTH (0xFFFFFFFC -> 0x00000000).
- out_addr_err is combinational on the head pc. Entries carrying an error are passed through unchanged.
- Producer contract: in_pc/in_instr must stay stable while in_valid=1 and in_ready=0; a bench assertion checks this. Consumer contract: out_* stable while out_valid=1 and out_ready=0, guaranteed by design.

Decomposition:
- Shared package (global.svh): word_t, and a fetch-entry struct {pc, instr} reused by other stage buffers.
- Natural sub-module: sync_fifo_ctrl (pointers, counter, full/empty). Storage array and pcplus4/addr_err logic stay in the top.

Test Plan:
- Reset then single push (pc=0xBFC00000, instr=0x24020001) with out_ready=1 -> next cycle out_valid=1, out_pcplus4=0xBFC00004, out_addr_err=0; following cycle out_valid=0.
- out_ready=0, push 3 entries back-to-back (pcs 0x100, 0x104, 0x108) with DEPTH=2 -> in_ready=0 after 2 accepts, out_count=2; third entry held by fetch. Raise out_ready -> pops return 0x100, 0x104, then 0x108 in order.
- Continuous push and pop every cycle for 10 cycles -> out_count constant at 1, pc sequence strictly +4, pointers wrap with no loss or duplication.
- Buffer full (2 entries), assert flush together with in_valid=1 -> next cycle out_valid=0, out_count=0; the flushed-cycle input never appears on the output.
- Push pc=0xFFFFFFFC, then pc=0x00000102 -> first entry gives out_pcplus4=0x00000000, addr_err=0; second gives addr_err=1, pcplus4=0x00000106.
- Assert reset for 1 cycle with 1 entry held and out_ready=0 -> in_ready=0 during reset; next cycle out_count=0, in_ready=1.
